// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data memory: one load/store at a time, RD_LAT latency, byte lanes, extension, faults.
// Optional DMEM_MISALIGN_SPLIT_EN: misaligned accesses complete, word-crossing ones as two word accesses.
module dmem_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         IW     = ADDR_W - 2;
  localparam int         DEPTH  = 2 ** IW;
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, PHASE2} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        live;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic [1:0]  lane;
  logic [2:0]  size;
  logic [3:0]  base_be;
  logic [32:0] last;
  logic        f3_ok, range_ok, misal, err;
  logic        ph2, go_ph2, exec, fin, wr_en;
  logic [IW-1:0] idx, idx_hi, rw_idx;
  logic [7:0]  be8;
  logic [3:0]  wr_be;
  logic [63:0] wd64, rd64;
  logic [31:0] wr_data, rd_word, lo_word, hi_word, raw, ext;

  assign off  = addr_q - BASE_ADDR;
  assign lane = addr_q[1:0];

  always_comb begin
    size    = 3'd4;
    base_be = 4'b1111;
    case (f3_q[1:0])
      2'b00:   begin size = 3'd1; base_be = 4'b0001; end
      2'b01:   begin size = 3'd2; base_be = 4'b0011; end
      default: begin size = 3'd4; base_be = 4'b1111; end
    endcase
  end

  assign f3_ok    = we_q ? (f3_q <= 3'd2) : (f3_q != 3'd3 && f3_q != 3'd6 && f3_q != 3'd7);
  // 33-bit arithmetic so addresses near 2**32 cannot wrap back into the window
  assign last     = {1'b0, off} + {30'b0, size} - 33'd1;
  assign range_ok = last < (33'd1 << ADDR_W);
  assign misal    = (f3_q[1:0] == 2'b01 && lane[0]) || (f3_q[1:0] == 2'b10 && lane != 2'b00);

  assign idx    = off[ADDR_W-1:2];
  assign idx_hi = idx + 1'b1;
  assign rw_idx = ph2 ? idx_hi : idx;
  assign be8    = {4'b0000, base_be} << lane;
  assign wd64   = {32'b0, wdata_q} << {lane, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic        cross;
  logic [31:0] lo_q;
  assign cross   = ({1'b0, lane} + size) > 3'd4;
  assign err     = !f3_ok || !range_ok;
  assign ph2     = (state == PHASE2);
  assign go_ph2  = cross && !err && !ph2;
  assign lo_word = ph2 ? lo_q : rd_word;
  assign hi_word = ph2 ? rd_word : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            lo_q <= 32'd0;
    else if (exec && go_ph2) lo_q <= rd_word;
  end
`else
  assign err     = !f3_ok || !range_ok || misal;
  assign ph2     = 1'b0;
  assign go_ph2  = 1'b0;
  assign lo_word = rd_word;
  assign hi_word = 32'd0;
`endif

  assign exec    = (state == WAIT || ph2) && cnt == 3'd0;
  assign fin     = exec && !go_ph2;
  assign wr_en   = exec && we_q && !err;
  assign wr_be   = ph2 ? be8[7:4] : be8[3:0];
  assign wr_data = ph2 ? wd64[63:32] : wd64[31:0];
  assign rd_word = mem[rw_idx];
  assign rd64    = {hi_word, lo_word} >> {lane, 3'b000};
  assign raw     = rd64[31:0];

  always_comb begin
    ext = raw;
    case (f3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'd0, raw[7:0]};
      3'b101:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem[rw_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        state_n = WAIT;
        cnt_n   = LAT_M1;
      end
      WAIT: if (cnt == 3'd0) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        // one extra cycle between the word accesses gives 2*RD_LAT+1 in total
        if (go_ph2) begin
          state_n = PHASE2;
          cnt_n   = 3'(RD_LAT);
        end else
`endif
        state_n = RESP;
      end else cnt_n = cnt - 3'd1;
`ifdef DMEM_MISALIGN_SPLIT_EN
      PHASE2: if (cnt == 3'd0) state_n = RESP;
              else cnt_n = cnt - 3'd1;
`endif
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live      <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        f3_q    <= req_func3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (fin) begin
        rsp_rdata <= (err || we_q) ? 32'd0 : ext;
        rsp_err   <= err;
      end
    end
  end

  assign req_ready = live && state == IDLE;
  assign rsp_valid = state == RESP;
endmodule
